// File: rtl/ibuf_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ibuf_queue_if : fill / consume / decode-window bundle of ibuf_queue |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface ibuf_queue_if;
    logic        ibuf_flush;
    logic        fill_vld;
    logic [2:0]  fill_nbytes;
    logic [31:0] fill_data;
    logic        ibuf_room;
    logic [2:0]  consume;
    logic [7:0]  ibuff_0;
    logic [7:0]  ibuff_1;
    logic [7:0]  ibuff_2;
    logic [7:0]  ibuff_3;
    logic [7:0]  ibuff_4;
    logic [7:0]  ibuff_5;
    logic [7:0]  ibuff_6;
    logic [6:0]  fetch_valid;
    logic [4:0]  ibuf_cnt;
    logic        ibuf_ovr;

    modport master (
        output ibuf_flush, fill_vld, fill_nbytes, fill_data, consume,
        input  ibuf_room, ibuff_0, ibuff_1, ibuff_2, ibuff_3, ibuff_4,
               ibuff_5, ibuff_6, fetch_valid, ibuf_cnt, ibuf_ovr
    );

    modport slave (
        input  ibuf_flush, fill_vld, fill_nbytes, fill_data, consume,
        output ibuf_room, ibuff_0, ibuff_1, ibuff_2, ibuff_3, ibuff_4,
               ibuff_5, ibuff_6, fetch_valid, ibuf_cnt, ibuf_ovr
    );
endinterface
`default_nettype wire

// File: rtl/ibuf_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ibuf_queue : byte-granular circular instruction buffer, 7-byte     |
// | decode window. Optional same-cycle fill bypass: IBUF_BYPASS_EN.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module ibuf_queue #(
    parameter int DEPTH  = 16,
    parameter int FILL_W = 4,
    parameter int PTR_W  = 4
) (
    input wire          clk,
    input wire          reset,
    ibuf_queue_if.slave ibq
);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovr;

    logic             w_room;
    logic             w_nb_ok;
    logic             w_acc;
    logic             w_over;
    logic [CNT_W-1:0] w_fill_n;
    logic [CNT_W-1:0] w_consume;
    logic [CNT_W-1:0] w_avail;
    logic [CNT_W-1:0] w_eff;
    logic [6:0]       w_fv;
    logic [7:0]       w_win [7];

    always_comb begin
        w_room    = (CNT_W'(DEPTH) - r_cnt) >= CNT_W'(FILL_W);
        w_nb_ok   = (ibq.fill_nbytes != 3'd0) && (ibq.fill_nbytes <= 3'(FILL_W));
        w_acc     = ibq.fill_vld & w_room & ~ibq.ibuf_flush;
        w_fill_n  = (w_acc && w_nb_ok) ? CNT_W'(ibq.fill_nbytes) : '0;
        w_consume = CNT_W'(ibq.consume);
`ifdef IBUF_BYPASS_EN
        // Bypassed fill bytes are already visible, so they may be retired now.
        w_avail   = r_cnt + w_fill_n;
`else
        w_avail   = r_cnt;
`endif
        w_over    = w_consume > w_avail;
        w_eff     = w_over ? w_avail : w_consume;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_ovr    <= 1'b0;
        end else if (ibq.ibuf_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_ovr    <= 1'b0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_eff);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_fill_n);
            r_cnt    <= r_cnt + w_fill_n - w_eff;
            if (w_over) begin
                r_ovr <= 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked solely by r_cnt.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FILL_W; k++) begin
            if (CNT_W'(k) < w_fill_n) begin
                r_mem[r_wr_ptr + PTR_W'(k)] <= ibq.fill_data[8*k +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < 7; gi++) begin : g_win
        logic       w_bit;
        logic [7:0] w_byte;
`ifdef IBUF_BYPASS_EN
        logic [CNT_W-1:0] w_off;
        always_comb begin
            w_off  = CNT_W'(gi) - r_cnt;
            w_bit  = r_cnt > CNT_W'(gi);
            w_byte = w_bit ? r_mem[r_rd_ptr + PTR_W'(gi)] : 8'h00;
            if (!w_bit && (CNT_W'(gi) < (r_cnt + w_fill_n))) begin
                w_bit  = 1'b1;
                w_byte = ibq.fill_data[{w_off[1:0], 3'b000} +: 8];
            end
        end
`else
        always_comb begin
            w_bit  = r_cnt > CNT_W'(gi);
            w_byte = w_bit ? r_mem[r_rd_ptr + PTR_W'(gi)] : 8'h00;
        end
`endif
        assign w_fv[gi]  = w_bit;
        assign w_win[gi] = w_byte;
    end

    assign ibq.ibuf_room   = w_room;
    assign ibq.fetch_valid = w_fv;
    assign ibq.ibuf_cnt    = 5'(r_cnt);
    assign ibq.ibuf_ovr    = r_ovr;
    assign ibq.ibuff_0     = w_win[0];
    assign ibq.ibuff_1     = w_win[1];
    assign ibq.ibuff_2     = w_win[2];
    assign ibq.ibuff_3     = w_win[3];
    assign ibq.ibuff_4     = w_win[4];
    assign ibq.ibuff_5     = w_win[5];
    assign ibq.ibuff_6     = w_win[6];
endmodule
`default_nettype wire
